// File: rtl/dual_diagonal_multiply_if.sv
// Stream bundle for dual_diagonal_multiply: parity-domain input stream and differenced output stream.
// Carries i_in_last only when DUAL_DIAGONAL_MULTIPLY_LAST_IN_EN is defined.
interface dual_diagonal_multiply_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] i_in_data;
  logic             i_in_valid;
  logic             o_in_ready;
`ifdef DUAL_DIAGONAL_MULTIPLY_LAST_IN_EN
  logic             i_in_last;
`endif
  logic [WIDTH-1:0] o_out_data;
  logic             o_out_valid;
  logic             o_out_last;
  logic             i_out_ready;

  modport master (
    output i_in_data,
    output i_in_valid,
    input  o_in_ready,
`ifdef DUAL_DIAGONAL_MULTIPLY_LAST_IN_EN
    output i_in_last,
`endif
    input  o_out_data,
    input  o_out_valid,
    input  o_out_last,
    output i_out_ready
  );

  modport slave (
    input  i_in_data,
    input  i_in_valid,
    output o_in_ready,
`ifdef DUAL_DIAGONAL_MULTIPLY_LAST_IN_EN
    input  i_in_last,
`endif
    output o_out_data,
    output o_out_valid,
    output o_out_last,
    input  i_out_ready
  );
endinterface

// File: rtl/dual_diagonal_multiply.sv
// Differencing stage: out[k] = in[k] ^ in[k-1] within each vector, latency 1, full throughput.
// Optional macro DUAL_DIAGONAL_MULTIPLY_LAST_IN_EN adds an i_in_last early-terminate input.
module dual_diagonal_multiply #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned NUM_WORDS = 1024
) (
  input logic                    i_clock,
  input logic                    i_reset_n,
  dual_diagonal_multiply_if.slave bus
);

  localparam int unsigned CntW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NUM_WORDS - 1);

  // Assertion is asynchronous; release is retimed to i_clock.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             in_fire;
  logic             word_last;

  assign bus.o_in_ready  = ~out_valid_q | bus.i_out_ready;
  assign bus.o_out_data  = out_data_q;
  assign bus.o_out_valid = out_valid_q;
  assign bus.o_out_last  = out_last_q;

  assign in_fire = bus.i_in_valid & bus.o_in_ready;

`ifdef DUAL_DIAGONAL_MULTIPLY_LAST_IN_EN
  assign word_last = (cnt_q == LastCnt) | bus.i_in_last;
`else
  assign word_last = (cnt_q == LastCnt);
`endif

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    prev_d      = prev_q;
    cnt_d       = cnt_q;
    if (in_fire) begin
      out_data_d  = bus.i_in_data ^ prev_q;
      out_valid_d = 1'b1;
      out_last_d  = word_last;
      // The next vector starts with no predecessor, so its first word passes through.
      prev_d      = word_last ? '0 : bus.i_in_data;
      cnt_d       = word_last ? '0 : cnt_q + 1'b1;
    end else if (bus.i_out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clock or negedge rst_int_n) begin
    if (!rst_int_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      prev_q      <= '0;
      cnt_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      prev_q      <= prev_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dual_diagonal_multiply.sv
// Scoreboard bench for dual_diagonal_multiply (WIDTH=8, NUM_WORDS=4): directed vectors,
// backpressure, mid-vector reset and a short parity round trip.
module tb_dual_diagonal_multiply;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic rt_mode;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } exp_t;

  exp_t sb_q[$];

  dual_diagonal_multiply_if #(.WIDTH(8)) bus ();

  dual_diagonal_multiply #(
    .WIDTH    (8),
    .NUM_WORDS(4)
  ) dut (
    .i_clock  (clk),
    .i_reset_n(rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every output transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      check("ready_rule", {31'd0, bus.o_in_ready}, {31'd0, ~bus.o_out_valid | bus.i_out_ready});
      if (bus.o_out_valid && bus.i_out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("out_data", {24'd0, bus.o_out_data}, {24'd0, e.data});
          check("out_last", {31'd0, bus.o_out_last}, {31'd0, e.last});
        end
      end
    end
  end

  // Random downstream stalls during the round trip only.
  always @(posedge clk) begin
    #1;
    if (rt_mode) bus.i_out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic [7:0] d, input logic [7:0] exp_d, input logic exp_l,
                      input logic l_in);
    logic acc;
    acc = 1'b0;
    bus.i_in_valid = 1'b1;
    bus.i_in_data  = d;
`ifdef DUAL_DIAGONAL_MULTIPLY_LAST_IN_EN
    bus.i_in_last  = l_in;
`endif
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      acc = bus.o_in_ready;
      if (acc) sb_q.push_back('{last: exp_l, data: exp_d});
      @(posedge clk);
      #1;
      if (acc) break;
    end
    bus.i_in_valid = 1'b0;
    bus.i_in_data  = 8'hEE;
`ifdef DUAL_DIAGONAL_MULTIPLY_LAST_IN_EN
    bus.i_in_last  = 1'b0;
`endif
    if (!acc) check("send_timeout", 32'd0, 32'd1);
    else check("latency1_valid", {31'd0, bus.o_out_valid}, 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || bus.o_out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", sb_q.size(), 32'd0);
  endtask

  initial begin
    logic [7:0] orig;
    logic [7:0] par;
    checks         = 0;
    failures       = 0;
    rt_mode        = 1'b0;
    rst_n          = 1'b0;
    bus.i_in_valid = 1'b0;
    bus.i_in_data  = 8'h00;
    bus.i_out_ready = 1'b1;
`ifdef DUAL_DIAGONAL_MULTIPLY_LAST_IN_EN
    bus.i_in_last  = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, bus.o_out_valid}, 32'd0);
    check("rst_data", {24'd0, bus.o_out_data}, 32'd0);
    check("rst_last", {31'd0, bus.o_out_last}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("ready_after_rst", {31'd0, bus.o_in_ready}, 32'd1);

    // Basic differencing, then vector boundary.
    send(8'h01, 8'h01, 1'b0, 1'b0);
    send(8'h03, 8'h02, 1'b0, 1'b0);
    send(8'h02, 8'h01, 1'b0, 1'b0);
    send(8'h06, 8'h04, 1'b1, 1'b0);
    send(8'h05, 8'h05, 1'b0, 1'b0);
    send(8'h05, 8'h00, 1'b0, 1'b0);

    // Backpressure: output 0x00 must hold, no input consumed.
    bus.i_out_ready = 1'b0;
    bus.i_in_valid  = 1'b1;
    bus.i_in_data   = 8'h07;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid", {31'd0, bus.o_out_valid}, 32'd1);
      check("bp_data", {24'd0, bus.o_out_data}, 32'd0);
      check("bp_in_ready", {31'd0, bus.o_in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    bus.i_in_valid  = 1'b0;
    bus.i_out_ready = 1'b1;
    send(8'h07, 8'h02, 1'b0, 1'b0);
    send(8'h07, 8'h00, 1'b1, 1'b0);
    drain();

    // Mid-vector reset after two words.
    send(8'h11, 8'h11, 1'b0, 1'b0);
    send(8'h13, 8'h02, 1'b0, 1'b0);
    bus.i_out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'd0, bus.o_out_valid}, 32'd0);
    check("midrst_data", {24'd0, bus.o_out_data}, 32'd0);
    check("midrst_last", {31'd0, bus.o_out_last}, 32'd0);
    sb_q.delete();
    bus.i_out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send(8'h0A, 8'h0A, 1'b0, 1'b0);
    send(8'h0B, 8'h01, 1'b0, 1'b0);
    send(8'h0B, 8'h00, 1'b0, 1'b0);
    send(8'h0C, 8'h07, 1'b1, 1'b0);
    drain();

    // Round trip through a running-XOR model with gaps and stalls.
    rt_mode = 1'b1;
    for (int v = 0; v < 3; v++) begin
      par = 8'h00;
      for (int k = 0; k < 4; k++) begin
        orig = 8'($urandom);
        par  = par ^ orig;
        send(par, orig, (k == 3), 1'b0);
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    rt_mode = 1'b0;
    @(posedge clk);
    #1;
    bus.i_out_ready = 1'b1;
    drain();

`ifdef DUAL_DIAGONAL_MULTIPLY_LAST_IN_EN
    // Early terminate on word 1; the next word starts a fresh vector.
    send(8'h21, 8'h21, 1'b0, 1'b0);
    send(8'h23, 8'h02, 1'b1, 1'b1);
    send(8'h30, 8'h30, 1'b0, 1'b0);
    send(8'h31, 8'h01, 1'b0, 1'b0);
    send(8'h32, 8'h03, 1'b0, 1'b0);
    send(8'h33, 8'h01, 1'b1, 1'b0);
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dual_diagonal_multiply.md
DUAL_DIAGONAL_MULTIPLY -- requirements
Module: dual_diagonal_multiply

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8: data word width in bits.
REQ-002 The module SHALL have parameter NUM_WORDS, default 1024: words per vector, at least 2.
REQ-003 The module SHALL have port i_clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port i_reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have port i_in_data, input, WIDTH bits: parity-domain word (running-XOR form).
REQ-006 The module SHALL have port i_in_valid, input, 1 bit: i_in_data valid.
REQ-007 The module SHALL have port o_in_ready, output, 1 bit: module accepts an input word this cycle.
REQ-008 The module SHALL have port o_out_data, output, WIDTH bits: differenced word.
REQ-009 The module SHALL have port o_out_valid, output, 1 bit: o_out_data valid.
REQ-010 The module SHALL have port o_out_last, output, 1 bit: qualifies the final word of a vector while o_out_valid is high.
REQ-011 The module SHALL have port i_out_ready, input, 1 bit: downstream accepts the output word.

Function
REQ-012 The module SHALL accept an input word only on a cycle where i_in_valid and o_in_ready are both high (input transfer).
REQ-013 The module SHALL complete an output transfer only on a cycle where o_out_valid and i_out_ready are both high.
REQ-014 o_in_ready SHALL equal (!o_out_valid | i_out_ready), combinationally.
REQ-015 For input word k of a vector, o_out_data SHALL be in[k] XOR in[k-1]; for k=0 it SHALL be in[0] XOR 0.
REQ-016 The module SHALL present each result on its output register the cycle after the input transfer: latency 1, throughput 1 word/cycle with i_out_ready held high.
REQ-017 The module SHALL hold a previous-word register, loaded with i_in_data on every input transfer except the last word of a vector, where it SHALL be cleared to 0.
REQ-018 The module SHALL hold a word counter of $clog2(NUM_WORDS) bits, incremented on each input transfer and wrapping from NUM_WORDS-1 to 0.
REQ-019 o_out_last SHALL be registered with the data: high iff the word producing it was counter value NUM_WORDS-1.
REQ-020 If an output transfer and an input transfer occur in the same cycle, the output register SHALL load the new word and o_out_valid SHALL stay high.
REQ-021 If an output transfer occurs with no input transfer, o_out_valid SHALL go low the next cycle.
REQ-022 While o_out_valid is high and i_out_ready is low, o_out_data, o_out_last and o_out_valid SHALL hold, and the counter and previous-word register SHALL not change.
REQ-023 i_in_data SHALL be ignored when no input transfer occurs; invalid cycles SHALL not break a vector.

Reset
REQ-024 Assertion of i_reset_n low SHALL immediately force the following to 0: o_out_valid, o_out_data, o_out_last, word counter, previous-word register.
REQ-025 Reset mid-vector SHALL discard the partial vector; the first word accepted after release SHALL be word 0 of a new vector.
REQ-026 Reset release SHALL be synchronised inside the block to i_clock; o_in_ready SHALL be high in the first cycle after release.

Configuration
REQ-027 With macro DUAL_DIAGONAL_MULTIPLY_LAST_IN_EN defined, the module SHALL add input port i_in_last (1 bit).
REQ-028 With DUAL_DIAGONAL_MULTIPLY_LAST_IN_EN defined, an input transfer with i_in_last high SHALL be treated as the final word of its vector regardless of count: o_out_last high, counter and previous-word register cleared.
REQ-029 Without DUAL_DIAGONAL_MULTIPLY_LAST_IN_EN, port i_in_last SHALL not exist and vector boundaries SHALL come from the counter alone.

Verification
REQ-030 Basic differencing: WIDTH=8, NUM_WORDS=4, i_out_ready=1; inputs 0x01,0x03,0x02,0x06 -> outputs 0x01,0x02,0x01,0x04, o_out_last on the 4th, each one cycle after input.
REQ-031 Vector boundary: continue that stream with 0x05,0x05 -> outputs 0x05 (no XOR with 0x06), then 0x00.
REQ-032 Backpressure: hold i_out_ready=0 for 3 cycles with a valid output -> output stable, o_in_ready=0, no input consumed; on release, no loss or duplication.
REQ-033 Mid-vector reset: pulse i_reset_n low after 2 words -> outputs clear at once; next input 0x0A -> output 0x0A, counter restarts at 0.
REQ-034 Round trip: random 1024-word vectors through the running-XOR backsub block, then this block, with random valid/ready gaps -> original words reproduced exactly, o_out_last every 1024th word.
REQ-035 With DUAL_DIAGONAL_MULTIPLY_LAST_IN_EN: i_in_last on word 1 (NUM_WORDS=4) -> o_out_last on output 1; next word passes unXORed.
